// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants and types for the MMIO controller slice.
//   - IO window base default and in-window register offsets
//   - debounce FSM state encoding
//   - helper returning the offset of LED channel k
package mmio_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;

    localparam logic [9:0] OFF_LED0 = 10'h060;
    localparam logic [9:0] OFF_SW   = 10'h070;
    localparam logic [9:0] OFF_TIDX = 10'h074;
    localparam logic [9:0] OFF_STAT = 10'h078;
    localparam logic [9:0] OFF_CNT  = 10'h07C;

    typedef enum logic [1:0] {
        DB_IDLE        = 2'd0,
        DB_ARM_PRESS   = 2'd1,
        DB_HELD        = 2'd2,
        DB_ARM_RELEASE = 2'd3
    } db_state_t;

    function automatic logic [9:0] led_off(input int k);
        return OFF_LED0 + 10'(4 * k);
    endfunction

endpackage

// File: rtl/mmio_debounce.sv
// mmio_debounce: debounce FSM for an already-synchronised button.
//   clk, rst : clock, async active-high reset
//   btn      : synchronised button level
//   level    : 1 while the button is considered held (HELD / ARM_RELEASE)
//   press    : one-cycle pulse for each accepted press
module mmio_debounce
    import mmio_pkg::*;
#(
    parameter int DB_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    db_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          press_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DB_IDLE;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            press <= press_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        press_n = 1'b0;
        case (state)
            DB_IDLE: begin
                if (btn) begin
                    state_n = DB_ARM_PRESS;
                    cnt_n   = '0;
                end
            end
            DB_ARM_PRESS: begin
                if (!btn) begin
                    state_n = DB_IDLE;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = DB_HELD;
                    cnt_n   = '0;
                    press_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DB_HELD: begin
                if (!btn) begin
                    state_n = DB_ARM_RELEASE;
                    cnt_n   = '0;
                end
            end
            DB_ARM_RELEASE: begin
                // any high sample during release means the button is still held
                if (btn) begin
                    state_n = DB_HELD;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = DB_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = DB_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign level = (state == DB_HELD) || (state == DB_ARM_RELEASE);

endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped IO block (LED channels, switches, test selector,
// debounced confirm button with press counter).
//   clk, rst              : clock, async active-high reset
//   io_addr/read/write    : CPU access (one-cycle strobes)
//   io_wdata              : write data
//   io_rdata/io_rvalid    : registered read data + one-cycle qualifier
//   io_err                : one-cycle pulse on a bad in-window access
//   switch_in/test_index  : async inputs, synchronised here
//   confirm_btn           : async bouncy button, synchronised + debounced
//   led_out               : LED channel k on bits [k*LED_W +: LED_W]
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter int          N_LED     = 2,
    parameter int          LED_W     = 16,
    parameter int          SW_W      = 8,
    parameter int          DB_CYCLES = 20000,
    parameter logic [31:0] IO_BASE   = IO_BASE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            io_addr,
    input  logic                   io_read,
    input  logic                   io_write,
    input  logic [31:0]            io_wdata,
    output logic [31:0]            io_rdata,
    output logic                   io_rvalid,
    output logic                   io_err,
    input  logic [SW_W-1:0]        switch_in,
    input  logic                   confirm_btn,
    input  logic [2:0]             test_index,
    output logic [N_LED*LED_W-1:0] led_out
);

    // two-flop synchronisers
    logic [SW_W-1:0] sw_s1, sw_s2;
    logic [2:0]      ti_s1, ti_s2;
    logic            btn_s1, btn_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            ti_s1  <= '0;
            ti_s2  <= '0;
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            sw_s1  <= switch_in;
            sw_s2  <= sw_s1;
            ti_s1  <= test_index;
            ti_s2  <= ti_s1;
            btn_s1 <= confirm_btn;
            btn_s2 <= btn_s1;
        end
    end

    logic btn_level, btn_press;

    mmio_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_s2),
        .level (btn_level),
        .press (btn_press)
    );

    // address decode
    logic [N_LED-1:0][LED_W-1:0] led_q;
    logic [N_LED-1:0]            led_sel;
    logic [9:0]                  off;
    logic                        in_win, led_hit, ro_hit, mapped, both;
    logic                        rd_ok, wr_led, err_n, stat_rd;
    logic [31:0]                 rd_mux;
    logic                        flag;
    logic [15:0]                 press_cnt;

    assign off    = io_addr[9:0];
    assign in_win = (io_addr[31:10] == IO_BASE[31:10]);
    assign both   = io_read & io_write;

    always_comb begin
        led_sel = '0;
        for (int k = 0; k < N_LED; k++) begin
            led_sel[k] = (off == led_off(k));
        end
    end

    assign led_hit = |led_sel;
    assign ro_hit  = (off == OFF_SW) || (off == OFF_TIDX) ||
                     (off == OFF_STAT) || (off == OFF_CNT);
    assign mapped  = led_hit | ro_hit;

    assign rd_ok   = in_win & io_read & ~io_write & mapped;
    assign wr_led  = in_win & io_write & ~io_read & led_hit;
    assign err_n   = in_win & (io_read | io_write) &
                     (both | ~mapped | (io_write & ro_hit));
    assign stat_rd = rd_ok & (off == OFF_STAT);

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < N_LED; k++) begin
            if (led_sel[k]) rd_mux[LED_W-1:0] = led_q[k];
        end
        if (off == OFF_SW)   rd_mux = 32'(sw_s2);
        if (off == OFF_TIDX) rd_mux = 32'(ti_s2);
        if (off == OFF_STAT) rd_mux = {30'b0, btn_level, flag};
        if (off == OFF_CNT)  rd_mux = {16'b0, press_cnt};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q     <= '0;
            io_rdata  <= '0;
            io_rvalid <= 1'b0;
            io_err    <= 1'b0;
            flag      <= 1'b0;
            press_cnt <= '0;
        end else begin
            for (int k = 0; k < N_LED; k++) begin
                if (wr_led && led_sel[k]) led_q[k] <= io_wdata[LED_W-1:0];
            end
            io_rvalid <= rd_ok;
            io_err    <= err_n;
            if (rd_ok) io_rdata <= rd_mux;
            // a press wins over the read-clear, so a coincident read
            // returns the old bit0 while the flag ends up set
            if (btn_press)    flag <= 1'b1;
            else if (stat_rd) flag <= 1'b0;
            if (btn_press) press_cnt <= press_cnt + 16'd1;
        end
    end

    assign led_out = led_q;

    logic unused_wdata;
    assign unused_wdata = ^io_wdata;

endmodule

// File: tb/tb_mmio_ctrl.sv
// tb_mmio_ctrl: directed + randomized self-checking bench for mmio_ctrl
// (N_LED=2, LED_W=16, SW_W=8, DB_CYCLES=4).
module tb_mmio_ctrl;

    localparam int DB = 4;
    localparam logic [31:0] BASE = 32'hFFFF_FC00;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] io_addr;
    logic        io_read, io_write;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        io_rvalid, io_err;
    logic [7:0]  switch_in;
    logic        confirm_btn;
    logic [2:0]  test_index;
    logic [31:0] led_out;

    int total = 0;
    int bad   = 0;

    // reference state
    logic [15:0] m_led [2];
    logic [7:0]  m_sw;
    logic [2:0]  m_ti;
    logic        m_flag;
    logic        m_level;
    logic [15:0] m_cnt;
    logic [31:0] m_rdata;

    mmio_ctrl #(.N_LED(2), .LED_W(16), .SW_W(8), .DB_CYCLES(DB), .IO_BASE(BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .io_addr     (io_addr),
        .io_read     (io_read),
        .io_write    (io_write),
        .io_wdata    (io_wdata),
        .io_rdata    (io_rdata),
        .io_rvalid   (io_rvalid),
        .io_err      (io_err),
        .switch_in   (switch_in),
        .confirm_btn (confirm_btn),
        .test_index  (test_index),
        .led_out     (led_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one-cycle access; results sampled 1 time unit after the capturing edge
    task automatic access(input logic [31:0] a, input logic rd, input logic wr,
                          input logic [31:0] d);
        io_addr = a; io_read = rd; io_write = wr; io_wdata = d;
        tick(1);
        io_read = 1'b0; io_write = 1'b0;
    endtask

    // reference decode: mapped read data for an in-window offset
    function automatic logic model_rd(input logic [9:0] off, output logic [31:0] d);
        d = 32'h0;
        case (off)
            10'h060: d = {16'h0, m_led[0]};
            10'h064: d = {16'h0, m_led[1]};
            10'h070: d = {24'h0, m_sw};
            10'h074: d = {29'h0, m_ti};
            10'h078: d = {30'h0, m_level, m_flag};
            10'h07C: d = {16'h0, m_cnt};
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    function automatic logic [31:0] led_vec();
        return {m_led[1], m_led[0]};
    endfunction

    logic [9:0]  offs [10];
    logic [31:0] d, a;
    logic        hit;

    initial begin
        offs = '{10'h060, 10'h064, 10'h068, 10'h06C, 10'h070,
                 10'h074, 10'h078, 10'h07C, 10'h040, 10'h000};
        rst = 1'b1; io_addr = 0; io_read = 0; io_write = 0; io_wdata = 0;
        switch_in = 0; confirm_btn = 0; test_index = 0;
        m_led[0] = 0; m_led[1] = 0; m_sw = 0; m_ti = 0;
        m_flag = 0; m_level = 0; m_cnt = 0; m_rdata = 0;
        tick(3);
        chk("rst_led", led_out, 0);
        chk("rst_rdata", io_rdata, 0);
        chk("rst_rvalid", {31'b0, io_rvalid}, 0);
        chk("rst_err", {31'b0, io_err}, 0);
        rst = 1'b0;
        tick(2);

        // LED write / readback
        access(BASE + 32'h60, 0, 1, 32'h0000_ABCD);
        m_led[0] = 16'hABCD;
        chk("led_wr_err", {31'b0, io_err}, 0);
        chk("led_wr_out", led_out, led_vec());
        access(BASE + 32'h60, 1, 0, 0);
        chk("led_rd_rvalid", {31'b0, io_rvalid}, 1);
        chk("led_rd_data", io_rdata, 32'h0000_ABCD);
        tick(1);
        chk("rvalid_pulse", {31'b0, io_rvalid}, 0);
        chk("rdata_hold", io_rdata, 32'h0000_ABCD);
        m_rdata = 32'h0000_ABCD;

        // switches
        switch_in = 8'h5A; m_sw = 8'h5A;
        tick(3);
        access(BASE + 32'h70, 1, 0, 0);
        chk("sw_rd", io_rdata, 32'h0000_005A);
        m_rdata = 32'h5A;

        // RO write and unmapped read
        access(BASE + 32'h70, 0, 1, 32'hFFFF_FFFF);
        chk("ro_wr_err", {31'b0, io_err}, 1);
        chk("ro_wr_rvalid", {31'b0, io_rvalid}, 0);
        tick(1);
        chk("err_pulse", {31'b0, io_err}, 0);
        access(BASE + 32'h40, 1, 0, 0);
        chk("unm_rd_err", {31'b0, io_err}, 1);
        chk("unm_rd_rvalid", {31'b0, io_rvalid}, 0);
        chk("unm_rd_hold", io_rdata, m_rdata);

        // randomized accesses against the reference
        for (int it = 0; it < 60; it++) begin
            int kind;
            logic [9:0] off;
            logic [31:0] wd;
            logic exp_rv, exp_err;
            m_sw = 8'($urandom); m_ti = 3'($urandom);
            switch_in = m_sw; test_index = m_ti;
            tick(3);
            kind = $urandom_range(0, 3);
            off = offs[$urandom_range(0, 9)];
            if (off == 10'h000) off = 10'($urandom) & 10'h3FC;
            a = {BASE[31:10], off};
            wd = $urandom;
            exp_rv = 0; exp_err = 0;
            case (kind)
                0: begin
                    access(a, 0, 1, wd);
                    if (off == 10'h060) m_led[0] = wd[15:0];
                    else if (off == 10'h064) m_led[1] = wd[15:0];
                    else exp_err = 1;
                end
                1: begin
                    access(a, 1, 0, 0);
                    hit = model_rd(off, d);
                    if (hit) begin exp_rv = 1; m_rdata = d; end
                    else exp_err = 1;
                end
                2: begin
                    a = $urandom;
                    if (a[31:10] == BASE[31:10]) a[31] = ~a[31];
                    access(a, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, wd);
                end
                default: begin
                    access(a, 1, 1, wd);
                    exp_err = 1;
                end
            endcase
            chk($sformatf("rnd%0d_k%0d_rvalid", it, kind), {31'b0, io_rvalid}, {31'b0, exp_rv});
            chk($sformatf("rnd%0d_k%0d_err", it, kind), {31'b0, io_err}, {31'b0, exp_err});
            chk($sformatf("rnd%0d_k%0d_rdata", it, kind), io_rdata, m_rdata);
            chk($sformatf("rnd%0d_k%0d_led", it, kind), led_out, led_vec());
        end

        // debounce: short pulse rejected
        confirm_btn = 1; tick(3); confirm_btn = 0; tick(12);
        access(BASE + 32'h78, 1, 0, 0);
        chk("short_stat", io_rdata, 32'h0);
        access(BASE + 32'h7C, 1, 0, 0);
        chk("short_cnt", io_rdata, 32'h0);

        // held press accepted
        confirm_btn = 1; tick(10);
        access(BASE + 32'h78, 1, 0, 0);
        chk("held_stat", io_rdata, 32'h3);
        access(BASE + 32'h7C, 1, 0, 0);
        chk("held_cnt", io_rdata, 32'h1);
        access(BASE + 32'h78, 1, 0, 0);
        chk("stat_clear", io_rdata, 32'h2);
        confirm_btn = 0; tick(12);
        m_cnt = 1; m_flag = 0;

        // randomized press runs: clearly short or clearly long, with long gaps
        for (int r = 0; r < 10; r++) begin
            int len;
            len = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : $urandom_range(8, 11);
            confirm_btn = 1; tick(len);
            confirm_btn = 0; tick(DB + 8);
            if (len >= 8) begin m_cnt = m_cnt + 1; m_flag = 1; end
            access(BASE + 32'h7C, 1, 0, 0);
            chk($sformatf("run%0d_len%0d_cnt", r, len), io_rdata, {16'h0, m_cnt});
            access(BASE + 32'h78, 1, 0, 0);
            chk($sformatf("run%0d_len%0d_stat", r, len), io_rdata, {31'h0, m_flag});
            m_flag = 0;
        end

        // reset in the middle of ARM_PRESS
        confirm_btn = 1; tick(4);
        rst = 1; tick(1);
        chk("mid_rst_led", led_out, 0);
        chk("mid_rst_rdata", io_rdata, 0);
        chk("mid_rst_flags", {30'b0, io_rvalid, io_err}, 0);
        tick(1);
        rst = 0;
        tick(4);
        access(BASE + 32'h78, 1, 0, 0);
        chk("post_rst_stat_early", io_rdata, 32'h0);
        access(BASE + 32'h7C, 1, 0, 0);
        chk("post_rst_cnt0", io_rdata, 32'h0);
        tick(10);
        access(BASE + 32'h78, 1, 0, 0);
        chk("post_rst_stat_late", io_rdata, 32'h3);
        access(BASE + 32'h7C, 1, 0, 0);
        chk("post_rst_cnt1", io_rdata, 32'h1);
        confirm_btn = 0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_ctrl.md
MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 The block SHALL have parameter N_LED, default 2, giving the number of LED output channels (1..4).
REQ-002 The block SHALL have parameter LED_W, default 16, giving the width of each LED channel (1..32).
REQ-003 The block SHALL have parameter SW_W, default 8, giving the switch input width (1..32).
REQ-004 The block SHALL have parameter DB_CYCLES, default 20000, giving the debounce stable-count threshold (>=2).
REQ-005 The block SHALL have parameter IO_BASE, default 32'hFFFF_FC00, giving the IO window base; the window is addr[31:10]==IO_BASE[31:10].
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 io_addr  in  32  byte address from ALU result.
REQ-009 io_read  in  1  read strobe, one cycle per access.
REQ-010 io_write  in  1  write strobe, one cycle per access.
REQ-011 io_wdata  in  32  write data.
REQ-012 io_rdata  out  32  registered read data.
REQ-013 io_rvalid  out  1  one-cycle pulse qualifying io_rdata.
REQ-014 io_err  out  1  one-cycle pulse on an access to an unmapped offset or with both strobes high.
REQ-015 switch_in  in  SW_W  asynchronous switch inputs.
REQ-016 confirm_btn  in  1  asynchronous, bouncy confirm button.
REQ-017 test_index  in  3  asynchronous test selector.
REQ-018 led_out  out  N_LED*LED_W  LED channel k on bits [k*LED_W +: LED_W].

Function
REQ-019 Offsets within the window: 0x60+4k LED channel k (RW, k<N_LED); 0x70 switches (RO, zero-extended); 0x74 test_index (RO, zero-extended); 0x78 status (bit0 confirm flag, bit1 button level; RO, read-clears bit0); 0x7C press counter (RO, 16 bits, zero-extended).
REQ-020 Accesses outside the window SHALL be ignored silently: no io_rvalid, no io_err.
REQ-021 Writes to an LED channel SHALL load io_wdata[LED_W-1:0] into that channel on the strobe edge; led_out reflects it the next cycle.
REQ-022 Reads SHALL have latency 1: io_rvalid and io_rdata valid the cycle after io_read; io_rdata holds its value until the next valid read.
REQ-023 Writes to RO offsets, or io_read and io_write high together, SHALL pulse io_err the next cycle and change no state; a read with both strobes high returns no io_rvalid.
REQ-024 switch_in, test_index and confirm_btn SHALL each pass a two-flop synchroniser before use.
REQ-025 Debounce FSM states: IDLE, ARM_PRESS, HELD, ARM_RELEASE.
REQ-026 IDLE->ARM_PRESS when the synced button is 1; counter cleared.
REQ-027 ARM_PRESS: counter increments while the button is 1; returns to IDLE if the button is 0 before the counter reaches DB_CYCLES-1; at DB_CYCLES-1 goes to HELD and emits an accepted-press event.
REQ-028 HELD->ARM_RELEASE when the button is 0; ARM_RELEASE->IDLE after DB_CYCLES consecutive 0 samples, back to HELD on any 1.
REQ-029 An accepted press SHALL set the status flag and increment the press counter, which wraps 0xFFFF->0x0000.
REQ-030 When a press event and a status read occur in the same cycle, the returned bit0 is the pre-event value and the flag SHALL end set.
REQ-031 Status bit1 reports 1 in HELD and ARM_RELEASE, else 0.

Reset
REQ-032 rst SHALL force led_out=0, io_rdata=0, io_rvalid=0, io_err=0, flag=0, press counter=0, FSM=IDLE, debounce counter=0, synchroniser flops=0.
REQ-033 rst asserted mid-debounce SHALL discard the partial count; no press event is emitted on release of reset.

Structure
REQ-034 Offset constants, FSM state encoding and IO_BASE default SHALL live in shared package mmio_pkg.
REQ-035 Debouncer SHALL be sub-module mmio_debounce (FSM + counter), exporting level and press-event.

Verification
REQ-036 Write 0x0000_ABCD to 0xFFFF_FC60, read it back -> led_out[15:0]=0xABCD; io_rvalid one cycle after the read; io_rdata=0x0000_ABCD.
REQ-037 switch_in=8'h5A, wait 3 cycles, read 0xFFFF_FC70 -> io_rdata=0x0000_005A.
REQ-038 DB_CYCLES=4, button pulsed high 3 cycles then low -> no flag; held 10 cycles -> status=0x3, counter=1; second status read -> bit0=0.
REQ-039 Write to 0xFFFF_FC70 or read 0xFFFF_FC40 -> io_err pulse one cycle, no state change, no io_rvalid.
REQ-040 rst asserted while in ARM_PRESS -> all outputs 0, FSM IDLE; release with the button held -> a new full DB_CYCLES count is required before the flag sets.
